// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous-read SRAM between instruction fetch and data ports.
// Latency: grant in the request cycle (combinational); read data and rvalid exactly one cycle after grant.
// Backpressure: a denied grant is the requester's stall. Build option ARB_STARVE_GUARD_EN forces a fetch after MAX_WAIT denials.
module sram_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  // instruction fetch port (read only)
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic            inst_gnt,
  output logic            inst_rvalid,
  output logic [DW-1:0]   inst_rdata,
  // data port (loads and byte-masked stores)
  input  logic            data_req,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_gnt,
  output logic            data_rvalid,
  output logic [DW-1:0]   data_rdata,
  // unified SRAM
  output logic            mem_en,
  output logic [DW/8-1:0] mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;

  // Who owns the SRAM read data arriving this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  owner_e owner;
  owner_e owner_nxt;

  logic inst_pri;   // fetch has waited long enough to override data priority
  logic inst_win;
  logic data_win;
  logic data_rd;

`ifdef ARB_STARVE_GUARD_EN
  localparam int            CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  assign inst_pri = (wait_cnt == WAIT_LIM);

  // Count consecutive denied fetch cycles; saturate at the limit, clear on grant or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!inst_req || inst_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end
`else
  // Without the guard data has strict priority; MAX_WAIT (always >= 1) has no effect.
  assign inst_pri = (MAX_WAIT < 0);
`endif

  // Pick at most one winner: data by default, fetch when alone or when starved.
  always_comb begin
    inst_win = 1'b0;
    data_win = 1'b0;
    if (inst_req && (!data_req || inst_pri)) begin
      inst_win = 1'b1;
    end else if (data_req) begin
      data_win = 1'b1;
    end
  end

  assign inst_gnt = inst_win;
  assign data_gnt = data_win;
  assign data_rd  = data_win && (data_wen == '0);

  // Steer the winner onto the SRAM; fetches never write.
  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (inst_win) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end else if (data_win) begin
      mem_en    = 1'b1;
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // Response owner register; reset drops any in-flight response at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_nxt;
    end
  end

  // Next owner: the read granted this cycle; stores complete at grant and return nothing.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (inst_win) begin
      owner_nxt = OWN_INST;
    end else if (data_rd) begin
      owner_nxt = OWN_DATA;
    end
  end

  assign inst_rvalid = (owner == OWN_INST);
  assign data_rvalid = (owner == OWN_DATA);

  // Read data is shared; the rvalid tells each side whether it is theirs.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Byte-lane count is only meaningful for whole-byte data widths.
  logic [BW-1:0] unused_lane_chk;
  assign unused_lane_chk = mem_wen;

endmodule
